// File: rtl/cnn_ctrl_pkg.sv
// Shared control types for the CNN datapath schedulers: FSM state encoding
// and the width of the completed-frame counter.
package cnn_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } sched_state_t;

    localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/sum_row_sched.sv
// Collects one row from each requester in fixed order, streams the rows to the
// downstream summer as start beats, then flushes it with zero-data drain beats.
module sum_row_sched
    import cnn_ctrl_pkg::*;
#(
    parameter int BitSize     = 8,
    parameter int NumOfNerves = 4,
    parameter int DepthIn     = 2
) (
    input  logic                                    clk,
    input  logic                                    res_n,
    input  logic                                    en,
    input  logic [DepthIn-1:0]                      row_valid,
    input  logic [DepthIn*NumOfNerves*BitSize-1:0]  row_data,
    output logic [DepthIn-1:0]                      row_ready,
    output logic                                    sum_valid,
    output logic                                    sum_start,
    output logic [NumOfNerves*BitSize-1:0]          sum_data,
    output logic                                    busy,
    output logic                                    frame_done,
    output logic [FRAME_CNT_W-1:0]                  frame_count
);

    localparam int ROW_BITS = NumOfNerves * BitSize;
    localparam int ROW_W    = $clog2(DepthIn + 1);
    localparam int DRAIN_W  = $clog2(NumOfNerves + 1);
    localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(DepthIn - 1);
    localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(NumOfNerves - 1);

    sched_state_t               state_reg, state_next;
    logic [ROW_W-1:0]           row_idx_reg, row_idx_next;
    logic [DRAIN_W-1:0]         drain_cnt_reg, drain_cnt_next;
    logic                       sum_valid_reg, sum_valid_next;
    logic                       sum_start_reg, sum_start_next;
    logic [ROW_BITS-1:0]        sum_data_reg, sum_data_next;
    logic                       frame_done_reg, frame_done_next;
    logic [FRAME_CNT_W-1:0]     frame_count_reg, frame_count_next;

    logic [ROW_BITS-1:0]        row_masked [DepthIn];
    logic [ROW_BITS-1:0]        sel_data;
    logic                       accept;

    // Grant decode: only the requester at row_idx can ever be accepted, so
    // other requesters' valids are ignored by construction.
    generate
        for (genvar gi = 0; gi < DepthIn; gi++) begin : g_req
            assign row_ready[gi]  = (state_reg == COLLECT) && (row_idx_reg == ROW_W'(gi));
            assign row_masked[gi] = row_ready[gi] ? row_data[gi*ROW_BITS +: ROW_BITS] : '0;
        end
    endgenerate

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < DepthIn; k++) begin
            sel_data = sel_data | row_masked[k];
        end
    end

    assign accept = |(row_valid & row_ready);

    always_comb begin
        state_next       = state_reg;
        row_idx_next     = row_idx_reg;
        drain_cnt_next   = drain_cnt_reg;
        sum_valid_next   = 1'b0;
        sum_start_next   = 1'b0;
        sum_data_next    = '0;
        frame_done_next  = 1'b0;
        frame_count_next = frame_count_reg;
        case (state_reg)
            IDLE: begin
                if (en) begin
                    state_next   = COLLECT;
                    row_idx_next = '0;
                end
            end
            COLLECT: begin
                if (accept) begin
                    sum_valid_next = 1'b1;
                    sum_start_next = 1'b1;
                    sum_data_next  = sel_data;
                    if (row_idx_reg == LAST_ROW) begin
                        state_next     = DRAIN;
                        drain_cnt_next = '0;
                    end else begin
                        row_idx_next = row_idx_reg + ROW_W'(1);
                    end
                end
            end
            DRAIN: begin
                sum_valid_next = 1'b1;
                if (drain_cnt_reg == LAST_DRAIN) begin
                    // Frame ends here; en decides between a gapless next frame and IDLE.
                    frame_done_next  = 1'b1;
                    frame_count_next = frame_count_reg + FRAME_CNT_W'(1);
                    drain_cnt_next   = '0;
                    row_idx_next     = '0;
                    state_next       = en ? COLLECT : IDLE;
                end else begin
                    drain_cnt_next = drain_cnt_reg + DRAIN_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_reg       <= IDLE;
            row_idx_reg     <= '0;
            drain_cnt_reg   <= '0;
            sum_valid_reg   <= 1'b0;
            sum_start_reg   <= 1'b0;
            sum_data_reg    <= '0;
            frame_done_reg  <= 1'b0;
            frame_count_reg <= '0;
        end else begin
            state_reg       <= state_next;
            row_idx_reg     <= row_idx_next;
            drain_cnt_reg   <= drain_cnt_next;
            sum_valid_reg   <= sum_valid_next;
            sum_start_reg   <= sum_start_next;
            sum_data_reg    <= sum_data_next;
            frame_done_reg  <= frame_done_next;
            frame_count_reg <= frame_count_next;
        end
    end

    assign sum_valid   = sum_valid_reg;
    assign sum_start   = sum_start_reg;
    assign sum_data    = sum_data_reg;
    assign frame_done  = frame_done_reg;
    assign frame_count = frame_count_reg;
    assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_sum_row_sched.sv
// Directed bench for sum_row_sched: expected beats, summer results and frame
// timing are queued as stimulus is set up and checked as the DUT emits them.
module tb_sum_row_sched;

    localparam int B  = 8;
    localparam int N  = 4;
    localparam int D  = 2;
    localparam int RB = N * B;

    logic              clk = 1'b0;
    logic              res_n;
    logic              en;
    logic [D-1:0]      row_valid;
    logic [D*RB-1:0]   row_data;
    logic [D-1:0]      row_ready;
    logic              sum_valid;
    logic              sum_start;
    logic [RB-1:0]     sum_data;
    logic              busy;
    logic              frame_done;
    logic [15:0]       frame_count;

    sum_row_sched #(.BitSize(B), .NumOfNerves(N), .DepthIn(D)) dut (
        .clk         (clk),
        .res_n       (res_n),
        .en          (en),
        .row_valid   (row_valid),
        .row_data    (row_data),
        .row_ready   (row_ready),
        .sum_valid   (sum_valid),
        .sum_start   (sum_start),
        .sum_data    (sum_data),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          start;
        logic [RB-1:0] data;
        logic          done;
    } beat_t;

    typedef struct {
        int bub;
        int gap;
    } frame_t;

    beat_t        beat_q [$];
    logic [B-1:0] elem_q [$];
    frame_t       frame_q [$];

    int tests = 0;
    int fails = 0;
    int frames_seen = 0;

    // Behavioural downstream summer plus frame timing trackers.
    logic [B-1:0] acc [N];
    logic         in_frame = 1'b0;
    int           dk = 0;
    int           bub = 0;
    int           gap = 0;
    frame_t       cur_rec;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [RB-1:0] make_row(input int e0, input int e1, input int e2, input int e3);
        return {B'(e3), B'(e2), B'(e1), B'(e0)};
    endfunction

    task automatic push_frame(input logic [RB-1:0] a, input logic [RB-1:0] b, input int nbub, input int ngap);
        beat_q.push_back('{1'b1, a, 1'b0});
        beat_q.push_back('{1'b1, b, 1'b0});
        for (int i = 0; i < N; i++) beat_q.push_back('{1'b0, '0, (i == N - 1)});
        for (int j = N - 1; j >= 0; j--) elem_q.push_back(B'(a[j*B +: B] + b[j*B +: B]));
        frame_q.push_back('{nbub, ngap});
    endtask

    task automatic reset_model();
        beat_q.delete();
        elem_q.delete();
        frame_q.delete();
        in_frame = 1'b0;
        dk = 0;
        bub = 0;
        gap = 0;
    endtask

    task automatic tick();
        beat_t e;
        @(negedge clk);
        if (sum_valid === 1'b1) begin
            if (beat_q.size() == 0) begin
                check("extra_beat", 64'(sum_valid), 64'd0);
            end else begin
                e = beat_q.pop_front();
                check("beat_start", 64'(sum_start), 64'(e.start));
                check("beat_data", 64'(sum_data), 64'(e.data));
                check("beat_done", 64'(frame_done), 64'(e.done));
            end
            if (sum_start === 1'b1) begin
                if (!in_frame) begin
                    in_frame = 1'b1;
                    dk = 0;
                    bub = 0;
                    if (frame_q.size() == 0) begin
                        check("extra_frame", 64'(sum_start), 64'd0);
                        cur_rec = '{0, -1};
                    end else begin
                        cur_rec = frame_q.pop_front();
                    end
                    if (cur_rec.gap >= 0) check("frame_gap", 64'(gap), 64'(cur_rec.gap));
                    for (int j = 0; j < N; j++) acc[j] = sum_data[j*B +: B];
                end else begin
                    for (int j = 0; j < N; j++) acc[j] = acc[j] + sum_data[j*B +: B];
                end
            end else begin
                if (dk < N && elem_q.size() != 0) check("summer_out", 64'(acc[N-1-dk]), 64'(elem_q.pop_front()));
                dk++;
            end
            if (frame_done === 1'b1) begin
                if (in_frame) check("row_bubbles", 64'(bub), 64'(cur_rec.bub));
                in_frame = 1'b0;
                gap = 0;
                frames_seen++;
            end
        end else begin
            check("idle_outputs", {frame_done, sum_start, sum_data}, 64'd0);
            if (in_frame) bub++;
            else gap++;
        end
    endtask

    task automatic wait_frames(input int target, input string tag);
        for (int i = 0; i < 60 && frames_seen < target; i++) tick();
        check(tag, 64'(frames_seen), 64'(target));
    endtask

    task automatic wait_ready(input logic [D-1:0] val, input string tag);
        int i = 0;
        while (row_ready !== val && i < 40) begin
            tick();
            i++;
        end
        check(tag, 64'(row_ready), 64'(val));
    endtask

    initial begin
        logic [RB-1:0] ra, rb;
        int base;
        res_n = 1'b0;
        en = 1'b0;
        row_valid = '0;
        row_data = '0;
        #12;
        check("rst_sum", {sum_valid, sum_start, sum_data}, 64'd0);
        check("rst_ctrl", {row_ready, busy, frame_done}, 64'd0);
        check("rst_count", 64'(frame_count), 64'd0);
        @(negedge clk);
        res_n = 1'b1;
        tick();
        check("idle_busy", 64'(busy), 64'd0);

        // Both rows valid throughout: 2 start beats, 4 drain beats, 44,33,22,11.
        ra = make_row(1, 2, 3, 4);
        rb = make_row(10, 20, 30, 40);
        push_frame(ra, rb, 0, -1);
        row_data = {rb, ra};
        row_valid = 2'b11;
        en = 1'b1;
        tick();
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_ready0", 64'(row_ready), 64'd1);
        en = 1'b0;
        wait_frames(1, "t1_frames");
        check("t1_idle", 64'(busy), 64'd0);
        check("t1_count", 64'(frame_count), 64'd1);
        row_valid = '0;
        tick();

        // Requester 1 withheld for 3 cycles: exactly 3 bubbles between row beats.
        ra = make_row(5, 6, 7, 8);
        rb = make_row(100, 0, 1, 255);
        push_frame(ra, rb, 3, -1);
        row_data = {rb, ra};
        row_valid = 2'b01;
        en = 1'b1;
        tick();
        en = 1'b0;
        wait_ready(2'b10, "t2_row1_grant");
        repeat (3) tick();
        row_valid = 2'b10;
        wait_frames(2, "t2_frames");
        check("t2_count", 64'(frame_count), 64'd2);
        row_valid = '0;
        tick();

        // Requester 1 valid while row 0 is being collected must stay ungranted.
        ra = make_row(17, 34, 51, 68);
        rb = make_row(3, 3, 3, 3);
        push_frame(ra, rb, 0, -1);
        row_data = {rb, ra};
        row_valid = 2'b10;
        en = 1'b1;
        tick();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_ready_order", 64'(row_ready), 64'd1);
            check("t3_no_accept", 64'(sum_valid), 64'd0);
        end
        row_valid = 2'b11;
        wait_frames(3, "t3_frames");
        check("t3_count", 64'(frame_count), 64'd3);
        row_valid = '0;
        tick();

        // Reset pulsed during COLLECT right after a row beat was registered.
        ra = make_row(9, 8, 7, 6);
        row_data = {rb, ra};
        beat_q.push_back('{1'b1, ra, 1'b0});
        frame_q.push_back('{0, -1});
        row_valid = 2'b01;
        en = 1'b1;
        tick();
        en = 1'b0;
        tick();
        #2;
        res_n = 1'b0;
        #1;
        check("rst2_sum", {sum_valid, sum_start, sum_data}, 64'd0);
        check("rst2_ctrl", {row_ready, busy, frame_done}, 64'd0);
        check("rst2_count", 64'(frame_count), 64'd0);
        reset_model();
        @(negedge clk);
        res_n = 1'b1;
        row_valid = '0;
        repeat (3) tick();
        check("t5_no_done", 64'(frames_seen), 64'd3);
        check("t5_count", 64'(frame_count), 64'd0);

        // Three back-to-back frames with en held; en dropped in the last DRAIN.
        base = frames_seen;
        en = 1'b1;
        row_valid = 2'b11;
        for (int f = 0; f < 3; f++) begin
            ra = make_row(f + 1, 2 * f + 3, 50, 200);
            rb = make_row(9, 7 * f, 60, 100);
            push_frame(ra, rb, 0, (f == 0) ? -1 : 0);
            row_data = {rb, ra};
            wait_ready(2'b10, "t4_row1_grant");
            tick();
            if (f == 2) en = 1'b0;
        end
        wait_frames(base + 3, "t4_frames");
        check("t4_busy", 64'(busy), 64'd0);
        check("t4_count", 64'(frame_count), 64'd3);
        tick();
        check("t4_idle_ready", 64'(row_ready), 64'd0);
        row_valid = '0;
        tick();
        check("beat_q_drained", 64'(beat_q.size()), 64'd0);
        check("elem_q_drained", 64'(elem_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sum_row_sched.md
SUM_ROW_SCHED -- requirements
Module: sum_row_sched

Interface
REQ-001 The block SHALL have parameter BitSize, default 8, width of one nerve value.
REQ-002 The block SHALL have parameter NumOfNerves, default 4, nerves per row and per result frame.
REQ-003 The block SHALL have parameter DepthIn, default 2, rows (requesters) summed per frame.
REQ-004 The block SHALL have port clk  in  1  single clock, rising edge.
REQ-005 The block SHALL have port res_n  in  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port en  in  1  permit new frames; sampled only in IDLE and on the final DRAIN cycle.
REQ-007 The block SHALL have port row_valid  in  DepthIn  requester k has a row available.
REQ-008 The block SHALL have port row_data  in  DepthIn x NumOfNerves x BitSize  row of requester k.
REQ-009 The block SHALL have port row_ready  out  DepthIn  one-hot grant to the requester being collected.
REQ-010 The block SHALL have port sum_valid  out  1  drives downstream summer in_valid.
REQ-011 The block SHALL have port sum_start  out  1  drives downstream summer in_start (one per row beat).
REQ-012 The block SHALL have port sum_data  out  NumOfNerves x BitSize  drives downstream summer in_data.
REQ-013 The block SHALL have port busy  out  1  high in COLLECT or DRAIN.
REQ-014 The block SHALL have port frame_done  out  1  one-cycle pulse with the last registered drain beat.
REQ-015 The block SHALL have port frame_count  out  16  completed frames, wraps at 2^16.

Function
REQ-016 The block SHALL implement FSM states IDLE, COLLECT, DRAIN.
REQ-017 IDLE SHALL go to COLLECT with row_idx=0 when en=1; otherwise it SHALL remain in IDLE.
REQ-018 In COLLECT, row_ready SHALL be one-hot at row_idx; requesters SHALL be served in strict order 0..DepthIn-1, with no reordering.
REQ-019 An accept SHALL occur when row_valid[row_idx]&row_ready[row_idx]; on the following cycle sum_valid=1, sum_start=1 and sum_data=row_data[row_idx] (registered, latency 1).
REQ-020 A cycle in COLLECT without an accept SHALL produce sum_valid=0, sum_start=0, sum_data=0 on the next cycle (bubble); there is no timeout.
REQ-021 An accept at row_idx=DepthIn-1 SHALL move the FSM to DRAIN with drain_cnt=0; any other accept SHALL increment row_idx.
REQ-022 DRAIN SHALL last exactly NumOfNerves cycles, with row_ready=0; each cycle SHALL register sum_valid=1, sum_start=0, sum_data=0, so the drain beats immediately follow the last row beat with no gap.
REQ-023 On the final DRAIN cycle, frame_done SHALL pulse with that registered beat, frame_count SHALL increment, and the FSM SHALL go to COLLECT (row_idx=0) if en=1, else to IDLE; back-to-back frames SHALL have zero idle cycles.
REQ-024 A change of en during COLLECT or DRAIN SHALL be ignored; the current frame always completes.
REQ-025 row_valid of non-selected requesters SHALL be ignored, and a held row_valid SHALL be counted only once per frame.
REQ-026 Per frame, the block SHALL deliver exactly DepthIn sum_start beats followed by NumOfNerves zero-data beats.
REQ-027 row_idx SHALL be $clog2(DepthIn+1) bits wide, and drain_cnt SHALL be $clog2(NumOfNerves+1) bits wide.

Reset
REQ-028 Asserting res_n low SHALL force, asynchronously: state=IDLE, row_idx=0, drain_cnt=0, sum_valid=0, sum_start=0, sum_data=0, row_ready=0, busy=0, frame_done=0, frame_count=0.
REQ-029 Reset mid-frame SHALL abandon the frame with no frame_done; the downstream summer shares res_n and is reset with it.

Structure
REQ-030 The state enum (IDLE, COLLECT, DRAIN) SHALL live in shared package cnn_ctrl_pkg, together with the frame_count width constant.
REQ-031 The block SHALL be a single module with no sub-modules; the integration top SHALL instantiate sys_sum with matching parameters.

Verification
REQ-032 The bench SHALL cover: defaults, both rows valid continuously, en=1, rows {1,2,3,4},{10,20,30,40} -> sum_start on 2 consecutive beats, then 4 zero beats, frame_done on the 4th, summer outputs 44,33,22,11.
REQ-033 The bench SHALL cover: row_valid[1] withheld 3 cycles -> 3 bubble cycles between row beats; sums unchanged.
REQ-034 The bench SHALL cover: en held high for 3 frames -> frame_count=3, no idle cycles between frames, and each summer result covers its own frame only.
REQ-035 The bench SHALL cover: en dropped during DRAIN -> current frame completes, then IDLE, busy=0.
REQ-036 The bench SHALL cover: res_n pulsed low during COLLECT -> all outputs 0 immediately, no frame_done, frame_count=0.
REQ-037 The bench SHALL cover: row_valid[1] high while row_idx=0 -> row_ready[1]=0 and no accept from requester 1.
